ptmch_spi_rx: RTL and testbench
===============================

# ptmch_spi_rx

SPI slave frame receiver that sits directly upstream of the pulse-match trigger core and feeds it register writes. It oversamples the external SPI pins in the CLK160M domain, assembles fixed-length address/data frames, validates frame length, and presents each good frame as a single write on a valid/ready port. All SPI signals are asynchronous to CLK160M and are synchronised here; downstream logic sees only CLK160M-domain writes.

## Interface
- ADDR_W, 8, register address width
- DATA_W, 16, register data width; frame length FRAME_W = ADDR_W + DATA_W (24 by default)
- SYNC_STAGES, 2, synchroniser depth on SPI_CS/SPI_CLK/SPI_MOSI (minimum 2)

- CLK160M  in  1  sole clock, from the system PLL
- RESET  in  1  synchronous, active-high reset
- SPI_CS  in  1  chip select, active low, asynchronous
- SPI_CLK  in  1  SPI clock, mode 0 (idle low, sample on rising edge), asynchronous
- SPI_MOSI  in  1  serial data, MSB first, asynchronous
- WR_VALID  out  1  write available
- WR_READY  in  1  consumer accepts write when WR_VALID & WR_READY
- WR_ADDR  out  ADDR_W  frame bits [FRAME_W-1 -: ADDR_W]
- WR_DATA  out  DATA_W  frame bits [DATA_W-1:0]
- ERR_CNT  out  8  saturating count of discarded frames

## Operation
- Synchronisers: SYNC_STAGES flops per pin plus one history flop for edge detection. Reset value 0 for all stages, so CS held low through reset is never seen as a falling edge.
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE -> SHIFT on synchronised CS falling edge. Clears the shift register and the bit counter.
  - SHIFT: on each synchronised SPI_CLK rising edge, shift in MOSI at LSB. Bit counter saturates at FRAME_W+1. SHIFT -> CHECK on CS rising edge.
  - CHECK (one cycle) -> IDLE.
    - Accept if count == FRAME_W and the output slot is free (WR_VALID = 0, or WR_READY = 1 in this cycle). Load WR_ADDR and WR_DATA, set WR_VALID.
    - Otherwise discard the frame and increment ERR_CNT. Discard causes: short frame, long frame, or slot occupied.
- Output: WR_VALID stays high with stable WR_ADDR and WR_DATA until the handshake completes; it clears the cycle after WR_VALID & WR_READY. Output slot is one entry deep; no queueing.
- Simultaneous CS rising and SPI_CLK rising edges detected in the same cycle: the bit is shifted and counted first, then the FSM moves to CHECK.
- CS falling edge while in CHECK is ignored. The master must keep CS high for at least 4 CLK160M cycles between frames.
- SPI_CLK edges seen in IDLE are ignored.
- RESET mid-frame: FSM -> IDLE, the partial frame is lost and is not counted as an error. WR_VALID = 0, ERR_CNT = 0.

## Timing
- Reset values: WR_VALID 0, WR_ADDR 0, WR_DATA 0, ERR_CNT 0, FSM IDLE.
- SPI_CLK ≤ 20 MHz. High and low phases ≥ 3 CLK160M cycles each. MOSI stable ≥ 3 cycles around the rising edge.
- Latency: WR_VALID rises SYNC_STAGES+3 CLK160M cycles after the first CLK160M edge that samples SPI_CS high. This is 5 cycles by default.
- WR_VALID → WR_READY handshake accepts in the same cycle. Back-to-back frames are accepted if the consumer drains within one frame time.

## Configuration
- PTMCH_SPI_ERRCNT_EN defined: ERR_CNT is an 8-bit saturating counter (holds at 255) incremented in every discarding CHECK.
- Not defined: ERR_CNT is tied to 0 and the counter logic is removed. Frames are still discarded under the same rules.

## Structure
- Shared package ptmch_pkg holds:
  - the default ADDR_W, DATA_W, FRAME_W localparams
  - the FSM state enum typedef (IDLE, SHIFT, CHECK)
  - a packed struct typedef for {addr, data} writes, reused by the trigger core's register bank.
- One sub-module: ptmch_sync_edge. It is a parameterised SYNC_STAGES synchroniser with rise/fall pulse outputs, instantiated three times; the MOSI instance leaves its edge outputs unused.

## Test plan
- Reset, then a 24-bit frame 0x12ABCD at 10 MHz with WR_READY=1 -> single WR_VALID pulse with WR_ADDR=0x12 and WR_DATA=0xABCD, 5 cycles after CS is sampled high; ERR_CNT=0.
- 23-bit and 25-bit frames -> WR_VALID never asserts; ERR_CNT=2 with the macro, 0 without.
- WR_READY=0, then two valid frames 0x010001 and 0x020002 -> output holds addr 0x01 / data 0x0001, second frame dropped, ERR_CNT=1. Raising WR_READY completes one handshake and WR_VALID clears the next cycle.
- Last SPI_CLK rise and CS rise land in the same CLK160M cycle on a 24-bit frame -> frame accepted with the correct LSB.
- RESET pulsed after 12 bits with CS still low, CS released 1 µs later -> no write, ERR_CNT=0, no false frame. The next full frame is accepted normally.
- 300 short frames with the macro defined -> ERR_CNT saturates at 255.

Source files
------------

// File: rtl/ptmch_pkg.sv
// Shared types and defaults for the pulse-match trigger SPI front end and register bank.
package ptmch_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_FRAME_W = DEF_ADDR_W + DEF_DATA_W;

    // Receiver FSM states
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck
    } rx_state_e;

    // One register write as seen by the trigger core register bank
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } reg_wr_t;

endpackage

// File: rtl/ptmch_spi_rx_if.sv
// Register-write valid/ready port between the SPI receiver (master) and its consumer (slave).
interface ptmch_spi_rx_if
    import ptmch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              WR_VALID;
    logic              WR_READY;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;

    modport master (
        output WR_VALID,
        output WR_ADDR,
        output WR_DATA,
        input  WR_READY
    );

    modport slave (
        input  WR_VALID,
        input  WR_ADDR,
        input  WR_DATA,
        output WR_READY
    );

endinterface

// File: rtl/ptmch_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with registered rise/fall pulses.
// All stages reset to 0, so a pin held low through reset never yields a falling edge.
module ptmch_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Shift the pin through the synchroniser and compare against the history flop
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        hist_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;
    end

    // Synchroniser, history and edge-pulse registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ptmch_spi_rx.sv
// SPI mode-0 slave frame receiver: oversamples SPI pins in the CLK160M domain, assembles
// ADDR_W+DATA_W bit frames MSB first and emits each good frame as one valid/ready write.
// Optional feature: define PTMCH_SPI_ERRCNT_EN to build the saturating discarded-frame counter;
// otherwise ERR_CNT is tied to 0.
module ptmch_spi_rx
    import ptmch_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   CLK160M,
    input  logic                   RESET,
    input  logic                   SPI_CS,
    input  logic                   SPI_CLK,
    input  logic                   SPI_MOSI,
    ptmch_spi_rx_if.master         wr,
    output logic [7:0]             ERR_CNT
);

    localparam int unsigned FRAME_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

    logic cs_rise, cs_fall;
    logic sclk_rise;
    logic mosi;

    ptmch_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i   (CLK160M),
        .rst_i   (RESET),
        .d_i     (SPI_CS),
        .level_o (),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    ptmch_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i   (CLK160M),
        .rst_i   (RESET),
        .d_i     (SPI_CLK),
        .level_o (),
        .rise_o  (sclk_rise),
        .fall_o  ()
    );

    ptmch_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i   (CLK160M),
        .rst_i   (RESET),
        .d_i     (SPI_MOSI),
        .level_o (mosi),
        .rise_o  (),
        .fall_o  ()
    );

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               accept;

    // Next-state logic for the frame FSM, shifter and one-entry output slot
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        accept     = 1'b0;

        if (wr_valid_q && wr.WR_READY) begin
            wr_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            StShift: begin
                // A bit arriving with the CS rise is still taken before leaving SHIFT
                if (sclk_rise) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], mosi};
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (cs_rise) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = StIdle;
                // Slot is free if empty or being drained this very cycle
                if ((cnt_q == CNT_FULL) && (!wr_valid_q || wr.WR_READY)) begin
                    accept     = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = shreg_q[FRAME_W-1 -: ADDR_W];
                    wr_data_d  = shreg_q[DATA_W-1:0];
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Frame FSM with registered write outputs
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shreg_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr.WR_VALID = wr_valid_q;
    assign wr.WR_ADDR  = wr_addr_q;
    assign wr.WR_DATA  = wr_data_q;

`ifdef PTMCH_SPI_ERRCNT_EN
    logic       discard;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of frames dropped in CHECK
    always_comb begin
        discard   = (state_q == StCheck) && !accept;
        err_cnt_d = err_cnt_q;
        if (discard && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;
`else
    assign ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_ptmch_spi_rx.sv
// Directed bench for ptmch_spi_rx. Honours PTMCH_SPI_ERRCNT_EN for ERR_CNT expectations.
module tb_ptmch_spi_rx;

`ifdef PTMCH_SPI_ERRCNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_cs = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int valid_cycles = 0;
    int hs_cnt = 0;

    ptmch_spi_rx_if wr ();

    ptmch_spi_rx dut (
        .CLK160M  (clk),
        .RESET    (rst),
        .SPI_CS   (spi_cs),
        .SPI_CLK  (spi_clk),
        .SPI_MOSI (spi_mosi),
        .wr       (wr),
        .ERR_CNT  (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr.WR_VALID === 1'b1) valid_cycles <= valid_cycles + 1;
        if (wr.WR_VALID === 1'b1 && wr.WR_READY === 1'b1) hs_cnt <= hs_cnt + 1;
    end

    // mode 0: normal end, 1: CS rises together with the last SPI_CLK rise, 2: leave CS low
    // 16 CLK160M cycles per bit (10 MHz SPI)
    task automatic send_frame(input logic [31:0] bits, input int n, input int mode);
        spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            repeat (8) @(negedge clk);
            spi_clk = 1'b1;
            if (mode == 1 && i == 0) begin
                spi_cs = 1'b1;
            end else begin
                repeat (8) @(negedge clk);
                spi_clk = 1'b0;
            end
        end
        if (mode == 0) begin
            repeat (8) @(negedge clk);
            spi_cs = 1'b1;
        end
    endtask

    task automatic test_reset();
        wr.WR_READY = 1'b1;
        rst = 1'b1;
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (wr.WR_VALID !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %0b expected 0", wr.WR_VALID);
        end
        n_checks++;
        if (wr.WR_ADDR !== 8'h00) begin
            n_fail++; $display("FAIL reset_addr: got %0h expected 0", wr.WR_ADDR);
        end
        n_checks++;
        if (wr.WR_DATA !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: got %0h expected 0", wr.WR_DATA);
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt);
        end
        // CS low through reset must not start a frame; releasing CS then must not emit one
        rst = 1'b0;
        repeat (10) @(negedge clk);
        spi_cs = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (valid_cycles !== 0 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_no_frame: got valid_cycles=%0d err=%0d expected 0/0",
                     valid_cycles, err_cnt);
        end
    endtask

    task automatic test_basic();
        logic exp_v;
        wr.WR_READY = 1'b1;
        send_frame(32'h0012ABCD, 24, 0);
        // WR_VALID rises on the 5th CLK160M cycle after CS is driven high
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_v = (k == 5);
            n_checks++;
            if (wr.WR_VALID !== exp_v) begin
                n_fail++;
                $display("FAIL basic_latency_c%0d: got %0b expected %0b", k, wr.WR_VALID, exp_v);
            end
            if (k == 5) begin
                n_checks++;
                if (wr.WR_ADDR !== 8'h12 || wr.WR_DATA !== 16'hABCD) begin
                    n_fail++;
                    $display("FAIL basic_payload: got %0h/%0h expected 12/abcd",
                             wr.WR_ADDR, wr.WR_DATA);
                end
            end
        end
        n_checks++;
        if (valid_cycles !== 1 || hs_cnt !== 1) begin
            n_fail++;
            $display("FAIL basic_single_pulse: got valid=%0d hs=%0d expected 1/1",
                     valid_cycles, hs_cnt);
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL basic_errcnt: got %0d expected 0", err_cnt);
        end
    endtask

    task automatic test_bad_len();
        int vc;
        logic [7:0] exp_err;
        vc = valid_cycles;
        exp_err = (ERR_EN != 0) ? 8'd2 : 8'd0;
        send_frame(32'h00123456, 23, 0);
        repeat (10) @(negedge clk);
        send_frame(32'h01ABCDEF, 25, 0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (valid_cycles !== vc) begin
            n_fail++; $display("FAIL badlen_valid: got %0d expected %0d", valid_cycles, vc);
        end
        n_checks++;
        if (err_cnt !== exp_err) begin
            n_fail++; $display("FAIL badlen_errcnt: got %0d expected %0d", err_cnt, exp_err);
        end
    endtask

    task automatic test_hold();
        int hs;
        logic [7:0] exp_err;
        exp_err = (ERR_EN != 0) ? 8'd3 : 8'd0;
        wr.WR_READY = 1'b0;
        send_frame(32'h00010001, 24, 0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr.WR_VALID !== 1'b1 || wr.WR_ADDR !== 8'h01 || wr.WR_DATA !== 16'h0001) begin
            n_fail++;
            $display("FAIL hold_first: got v=%0b %0h/%0h expected 1 01/0001",
                     wr.WR_VALID, wr.WR_ADDR, wr.WR_DATA);
        end
        send_frame(32'h00020002, 24, 0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr.WR_VALID !== 1'b1 || wr.WR_ADDR !== 8'h01 || wr.WR_DATA !== 16'h0001) begin
            n_fail++;
            $display("FAIL hold_kept: got v=%0b %0h/%0h expected 1 01/0001",
                     wr.WR_VALID, wr.WR_ADDR, wr.WR_DATA);
        end
        n_checks++;
        if (err_cnt !== exp_err) begin
            n_fail++; $display("FAIL hold_errcnt: got %0d expected %0d", err_cnt, exp_err);
        end
        hs = hs_cnt;
        wr.WR_READY = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wr.WR_VALID !== 1'b0) begin
            n_fail++; $display("FAIL hold_clear: got %0b expected 0", wr.WR_VALID);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (hs_cnt !== hs + 1) begin
            n_fail++; $display("FAIL hold_handshakes: got %0d expected %0d", hs_cnt, hs + 1);
        end
    endtask

    task automatic test_simultaneous();
        logic exp_v;
        wr.WR_READY = 1'b1;
        send_frame(32'h005A3C81, 24, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_v = (k == 5);
            n_checks++;
            if (wr.WR_VALID !== exp_v) begin
                n_fail++;
                $display("FAIL simul_latency_c%0d: got %0b expected %0b", k, wr.WR_VALID, exp_v);
            end
            if (k == 5) begin
                n_checks++;
                if (wr.WR_ADDR !== 8'h5A || wr.WR_DATA !== 16'h3C81) begin
                    n_fail++;
                    $display("FAIL simul_payload: got %0h/%0h expected 5a/3c81",
                             wr.WR_ADDR, wr.WR_DATA);
                end
            end
        end
        spi_clk = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int vc;
        vc = valid_cycles;
        send_frame(32'h00000ABC, 12, 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (160) @(negedge clk);
        spi_cs = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (valid_cycles !== vc) begin
            n_fail++; $display("FAIL midreset_valid: got %0d expected %0d", valid_cycles, vc);
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL midreset_errcnt: got %0d expected 0", err_cnt);
        end
        send_frame(32'h00C30F0F, 24, 0);
        repeat (5) @(negedge clk);
        n_checks++;
        if (wr.WR_VALID !== 1'b1 || wr.WR_ADDR !== 8'hC3 || wr.WR_DATA !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL midreset_next: got v=%0b %0h/%0h expected 1 c3/0f0f",
                     wr.WR_VALID, wr.WR_ADDR, wr.WR_DATA);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (valid_cycles !== vc + 1 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_after: got valid=%0d err=%0d expected %0d/0",
                     valid_cycles, err_cnt, vc + 1);
        end
    endtask

    task automatic test_saturate();
        int nframes;
        int vc;
        logic [7:0] exp_err;
        nframes = (ERR_EN != 0) ? 300 : 3;
        exp_err = (ERR_EN != 0) ? 8'd255 : 8'd0;
        vc = valid_cycles;
        for (int f = 0; f < nframes; f++) begin
            send_frame(32'h00000001, 1, 0);
            repeat (8) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (err_cnt !== exp_err) begin
            n_fail++; $display("FAIL saturate_errcnt: got %0d expected %0d", err_cnt, exp_err);
        end
        n_checks++;
        if (valid_cycles !== vc) begin
            n_fail++; $display("FAIL saturate_valid: got %0d expected %0d", valid_cycles, vc);
        end
    endtask

    initial begin
        wr.WR_READY = 1'b1;
        test_reset();
        test_basic();
        test_bad_len();
        test_hold();
        test_simultaneous();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
